// File: rtl/ld_st_port_ctrl.sv
// ld_st_port_ctrl: drains load/store buffer heads onto the single cache data port.
// Define LDST_CTRL_STARVE_EN to enable the store starvation counter.
module ld_st_port_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BITS      = 32,
  parameter int BLOCK_ID_START = 5,
  parameter int R_WIDTH        = 6,
  parameter int MICROOP        = 5,
  parameter int ROB_TICKET     = 3,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  input  logic                  st_valid,
  input  logic                  ld_head_isfetched,
  input  logic                  st_head_isfetched,
  input  logic [ADDR_BITS-1:0]  ld_head_address,
  input  logic [ADDR_BITS-1:0]  st_head_address,
  input  logic [MICROOP-1:0]    ld_head_microop,
  input  logic [MICROOP-1:0]    st_head_microop,
  input  logic [R_WIDTH-1:0]    ld_head_dest,
  input  logic [ROB_TICKET-1:0] ld_head_ticket,
  input  logic [DATA_WIDTH-1:0] st_head_data,
  output logic                  ld_pop,
  output logic                  st_pop,
  output logic                  cache_req,
  output logic                  cache_we,
  output logic [ADDR_BITS-1:0]  cache_address,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic [MICROOP-1:0]    cache_microop,
  input  logic                  cache_gnt,
  input  logic                  cache_rvalid,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  miss_req,
  output logic [ADDR_BITS-1:0]  miss_address,
  input  logic                  miss_ack,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [R_WIDTH-1:0]    wb_dest,
  output logic [ROB_TICKET-1:0] wb_ticket,
  output logic [MICROOP-1:0]    wb_microop
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, LD_WAIT, LD_WB
  } state_t;

  state_t state, state_nx;

  logic                  lat_we;
  logic [ADDR_BITS-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [MICROOP-1:0]    lat_uop;
  logic [R_WIDTH-1:0]    lat_dest;
  logic [ROB_TICKET-1:0] lat_tkt;
  logic [DATA_WIDTH-1:0] lat_rdata;

  function automatic logic [ADDR_BITS-1:0] blk_of(
    input logic [ADDR_BITS-1:0] a
  );
    logic [ADDR_BITS-1:0] b;
    b = a;
    b[BLOCK_ID_START-1:0] = '0;
    return b;
  endfunction

  logic same_blk;
  logic ld_elig;
  logic st_elig;
  logic starve;
  logic pick_st;
  logic start;
  logic st_gnt;
  logic ld_gnt;

  assign same_blk = blk_of(ld_head_address)
                 == blk_of(st_head_address);
  // Same-block load waits behind the store (RAW).
  assign ld_elig = ld_valid & ld_head_isfetched
                 & ~(st_valid & same_blk);
  assign st_elig = st_valid & st_head_isfetched;
  assign start   = ld_elig | st_elig;
  assign st_gnt  = (state == ISSUE) & cache_gnt & lat_we;
  assign ld_gnt  = (state == ISSUE) & cache_gnt & ~lat_we;

`ifdef LDST_CTRL_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (st_gnt) begin
      starve_cnt <= '0;
    end else if (ld_gnt && st_elig
                 && starve_cnt != CW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign starve = (starve_cnt == CW'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  assign pick_st = st_elig & (~ld_elig | starve);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   if (cache_gnt)
                 state_nx = lat_we ? IDLE : LD_WAIT;
      LD_WAIT: if (cache_rvalid) state_nx = LD_WB;
      LD_WB:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cache_req = 1'b0;
    st_pop    = 1'b0;
    ld_pop    = 1'b0;
    wb_valid  = 1'b0;
    unique case (1'b1)
      (state == ISSUE): begin
        cache_req = 1'b1;
        st_pop    = lat_we & cache_gnt;
      end
      (state == LD_WB): begin
        ld_pop   = 1'b1;
        wb_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_uop   <= '0;
      lat_dest  <= '0;
      lat_tkt   <= '0;
      lat_rdata <= '0;
    end else begin
      if (state == IDLE && start) begin
        lat_we <= pick_st;
        if (pick_st) begin
          lat_addr <= st_head_address;
          lat_data <= st_head_data;
          lat_uop  <= st_head_microop;
          lat_dest <= '0;
          lat_tkt  <= '0;
        end else begin
          lat_addr <= ld_head_address;
          lat_data <= '0;
          lat_uop  <= ld_head_microop;
          lat_dest <= ld_head_dest;
          lat_tkt  <= ld_head_ticket;
        end
      end
      if (state == LD_WAIT && cache_rvalid)
        lat_rdata <= cache_rdata;
    end
  end

  assign cache_we      = lat_we;
  assign cache_address = lat_addr;
  assign cache_wdata   = lat_data;
  assign cache_microop = lat_uop;
  assign wb_data       = lat_rdata;
  assign wb_dest       = lat_dest;
  assign wb_ticket     = lat_tkt;
  assign wb_microop    = lat_uop;

  logic                 ld_ms;
  logic                 st_ms;
  logic                 m_busy;
  logic                 m_side;
  logic [ADDR_BITS-1:0] m_addr;
  logic                 ld_cand;
  logic                 st_cand;
  logic                 m_done;
  logic                 ld_ms_set;
  logic                 st_ms_set;

  assign ld_cand = ld_valid & ~ld_head_isfetched & ~ld_ms;
  assign st_cand = st_valid & ~st_head_isfetched & ~st_ms;
  assign m_done  = m_busy & miss_ack;

  // One refill covers both heads when they share the block.
  assign ld_ms_set = m_done & (~m_side
    | (ld_valid & blk_of(ld_head_address) == m_addr));
  assign st_ms_set = m_done & (m_side
    | (st_valid & blk_of(st_head_address) == m_addr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_side <= 1'b0;
      m_addr <= '0;
    end else if (m_busy) begin
      if (miss_ack) m_busy <= 1'b0;
    end else if (ld_cand || st_cand) begin
      m_busy <= 1'b1;
      m_side <= ~ld_cand;
      m_addr <= ld_cand ? blk_of(ld_head_address)
                        : blk_of(st_head_address);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_ms <= 1'b0;
      st_ms <= 1'b0;
    end else begin
      ld_ms <= ld_pop ? 1'b0 : (ld_ms | ld_ms_set);
      st_ms <= st_pop ? 1'b0 : (st_ms | st_ms_set);
    end
  end

  assign miss_req     = m_busy;
  assign miss_address = m_addr;

endmodule

// File: tb/tb_ld_st_port_ctrl.sv
// tb_ld_st_port_ctrl: random buffers/cache/refill environment
// checked every cycle against a transaction-level model.
module tb_ld_st_port_ctrl;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        ld_valid, st_valid;
  logic        ld_head_isfetched, st_head_isfetched;
  logic [31:0] ld_head_address, st_head_address;
  logic [4:0]  ld_head_microop, st_head_microop;
  logic [5:0]  ld_head_dest;
  logic [2:0]  ld_head_ticket;
  logic [31:0] st_head_data;
  logic        ld_pop, st_pop;
  logic        cache_req, cache_we;
  logic [31:0] cache_address, cache_wdata;
  logic [4:0]  cache_microop;
  logic        cache_gnt, cache_rvalid;
  logic [31:0] cache_rdata;
  logic        miss_req;
  logic [31:0] miss_address;
  logic        miss_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [5:0]  wb_dest;
  logic [2:0]  wb_ticket;
  logic [4:0]  wb_microop;

  ld_st_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .st_valid(st_valid),
    .ld_head_isfetched(ld_head_isfetched),
    .st_head_isfetched(st_head_isfetched),
    .ld_head_address(ld_head_address),
    .st_head_address(st_head_address),
    .ld_head_microop(ld_head_microop),
    .st_head_microop(st_head_microop),
    .ld_head_dest(ld_head_dest),
    .ld_head_ticket(ld_head_ticket),
    .st_head_data(st_head_data),
    .ld_pop(ld_pop), .st_pop(st_pop),
    .cache_req(cache_req), .cache_we(cache_we),
    .cache_address(cache_address),
    .cache_wdata(cache_wdata),
    .cache_microop(cache_microop),
    .cache_gnt(cache_gnt),
    .cache_rvalid(cache_rvalid),
    .cache_rdata(cache_rdata),
    .miss_req(miss_req), .miss_address(miss_address),
    .miss_ack(miss_ack),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_ticket(wb_ticket),
    .wb_microop(wb_microop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  uop;
    logic [5:0]  dest;
    logic [2:0]  tkt;
    logic        fetched;
  } ent_t;

  typedef struct packed {
    logic        act;
    logic        is_st;
    logic        granted;
    logic        returned;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [4:0]  uop;
    logic [5:0]  dest;
    logic [2:0]  tkt;
  } txn_t;

  ent_t ldq[$];
  ent_t stq[$];

  txn_t        tx;
  int          starve;
  logic        m_pend;
  logic [31:0] m_addr;
  logic        m_ld, m_st;

  logic e_req, e_stpop, e_wb;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rst_cnt = 3;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] blk(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic ent_t new_ent();
    ent_t e;
    e.addr    = 32'h100 + (($urandom % 6) << 5)
              + (($urandom % 8) << 2);
    e.data    = $urandom;
    e.uop     = 5'($urandom);
    e.dest    = 6'($urandom);
    e.tkt     = 3'($urandom);
    e.fetched = ($urandom % 4) != 0;
    return e;
  endfunction

  task automatic model_reset();
    tx     = '0;
    starve = 0;
    m_pend = 1'b0;
    m_addr = '0;
    m_ld   = 1'b0;
    m_st   = 1'b0;
  endtask

  task automatic drive();
    if (rst_cnt > 0) begin
      rst_n = 1'b0;
      rst_cnt--;
    end else begin
      rst_n = 1'b1;
      if ($urandom % 400 == 0) rst_cnt = 1 + $urandom % 2;
    end
    ld_valid = ldq.size() != 0;
    st_valid = stq.size() != 0;
    if (ld_valid) begin
      ld_head_address   = ldq[0].addr;
      ld_head_microop   = ldq[0].uop;
      ld_head_dest      = ldq[0].dest;
      ld_head_ticket    = ldq[0].tkt;
      ld_head_isfetched = ldq[0].fetched;
    end else begin
      ld_head_address   = $urandom;
      ld_head_microop   = 5'($urandom);
      ld_head_dest      = 6'($urandom);
      ld_head_ticket    = 3'($urandom);
      ld_head_isfetched = 1'($urandom);
    end
    if (st_valid) begin
      st_head_address   = stq[0].addr;
      st_head_data      = stq[0].data;
      st_head_microop   = stq[0].uop;
      st_head_isfetched = stq[0].fetched;
    end else begin
      st_head_address   = $urandom;
      st_head_data      = $urandom;
      st_head_microop   = 5'($urandom);
      st_head_isfetched = 1'($urandom);
    end
    cache_gnt    = 1'($urandom);
    cache_rvalid = ($urandom % 3) == 0;
    cache_rdata  = $urandom;
    miss_ack     = ($urandom % 3) == 0;
  endtask

  task automatic compare();
    check("cache_req", 32'(cache_req), 32'(e_req));
    check("st_pop", 32'(st_pop), 32'(e_stpop));
    check("ld_pop", 32'(ld_pop), 32'(e_wb));
    check("wb_valid", 32'(wb_valid), 32'(e_wb));
    check("miss_req", 32'(miss_req), 32'(m_pend));
    if (e_req) begin
      check("cache_we", 32'(cache_we), 32'(tx.is_st));
      check("cache_address", cache_address, tx.addr);
      check("cache_microop", 32'(cache_microop), 32'(tx.uop));
      if (tx.is_st) check("cache_wdata", cache_wdata, tx.data);
    end
    if (e_wb) begin
      check("wb_data", wb_data, tx.rdata);
      check("wb_dest", 32'(wb_dest), 32'(tx.dest));
      check("wb_ticket", 32'(wb_ticket), 32'(tx.tkt));
      check("wb_microop", 32'(wb_microop), 32'(tx.uop));
    end
    if (m_pend) check("miss_address", miss_address, m_addr);
  endtask

  task automatic zero_check();
    check("rst cache_we", 32'(cache_we), 0);
    check("rst cache_address", cache_address, 0);
    check("rst cache_wdata", cache_wdata, 0);
    check("rst cache_microop", 32'(cache_microop), 0);
    check("rst miss_address", miss_address, 0);
    check("rst wb_data", wb_data, 0);
    check("rst wb_dest", 32'(wb_dest), 0);
    check("rst wb_ticket", 32'(wb_ticket), 0);
  endtask

  task automatic update();
    logic raw, ld_el, st_el, take_st, hit;
    logic set_ld, set_st;
    logic [31:0] fb;
    set_ld = 1'b0;
    set_st = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      raw   = ld_valid && st_valid
           && blk(ld_head_address) == blk(st_head_address);
      ld_el = ld_valid && ld_head_isfetched && !raw;
      st_el = st_valid && st_head_isfetched;
`ifdef LDST_CTRL_STARVE_EN
      hit = starve >= LIMIT;
`else
      hit = 1'b0;
`endif
      if (!tx.act) begin
        if (ld_el || st_el) begin
          take_st = st_el && (!ld_el || hit);
          tx = '0;
          tx.act   = 1'b1;
          tx.is_st = take_st;
          if (take_st) begin
            tx.addr = st_head_address;
            tx.data = st_head_data;
            tx.uop  = st_head_microop;
          end else begin
            tx.addr = ld_head_address;
            tx.uop  = ld_head_microop;
            tx.dest = ld_head_dest;
            tx.tkt  = ld_head_ticket;
          end
        end
      end else if (!tx.granted) begin
        if (cache_gnt) begin
          if (tx.is_st) begin
            tx.act = 1'b0;
            starve = 0;
          end else begin
            tx.granted = 1'b1;
            if (st_el && starve < LIMIT) starve++;
          end
        end
      end else if (!tx.returned) begin
        if (cache_rvalid) begin
          tx.returned = 1'b1;
          tx.rdata    = cache_rdata;
        end
      end else begin
        tx.act = 1'b0;
      end

      if (m_pend) begin
        if (miss_ack) begin
          m_pend = 1'b0;
          set_ld = ld_valid && blk(ld_head_address) == m_addr;
          set_st = st_valid && blk(st_head_address) == m_addr;
          fb = m_addr;
          foreach (ldq[i])
            if (blk(ldq[i].addr) == fb) ldq[i].fetched = 1'b1;
          foreach (stq[i])
            if (blk(stq[i].addr) == fb) stq[i].fetched = 1'b1;
        end
      end else if (ld_valid && !ld_head_isfetched && !m_ld) begin
        m_pend = 1'b1;
        m_addr = blk(ld_head_address);
      end else if (st_valid && !st_head_isfetched && !m_st) begin
        m_pend = 1'b1;
        m_addr = blk(st_head_address);
      end
      m_ld = e_wb    ? 1'b0 : (m_ld | set_ld);
      m_st = e_stpop ? 1'b0 : (m_st | set_st);
    end
    if (e_wb)    void'(ldq.pop_front());
    if (e_stpop) void'(stq.pop_front());
    if (ldq.size() < 4 && $urandom % 2 == 0) ldq.push_back(new_ent());
    if (stq.size() < 4 && $urandom % 3 == 0) stq.push_back(new_ent());
  endtask

  initial begin
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      drive();
      #1;
      e_req   = tx.act && !tx.granted;
      e_stpop = e_req && tx.is_st && cache_gnt;
      e_wb    = tx.act && tx.returned;
      if (cyc == 1) zero_check();
      if (cyc > 0) compare();
      @(posedge clk);
      update();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ld_st_port_ctrl.md
# ld_st_port_ctrl

Drain controller between the data cache's load buffer and store buffer heads and the single cache data-array port. Each cycle it picks at most one fetched head (load or store), issues it to the port with a req/gnt handshake, returns load data to writeback and pops the served buffer. For unfetched heads it raises one block-miss request per head toward the refill path.

## Interface
- DATA_WIDTH, 32, data bits
- ADDR_BITS, 32, address bits
- BLOCK_ID_START, 5, first address bit of block ID
- R_WIDTH, 6, destination register bits
- MICROOP, 5, microop bits
- ROB_TICKET, 3, ROB ticket bits
- STARVE_LIMIT, 4, consecutive load grants tolerated while a store is eligible (≥1)

- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- ld_valid / st_valid  in  1  buffer non-empty
- ld_head_isfetched / st_head_isfetched  in  1  head block resident
- ld_head_address / st_head_address  in  ADDR_BITS  head address
- ld_head_microop / st_head_microop  in  MICROOP  head microop
- ld_head_dest  in  R_WIDTH; ld_head_ticket  in  ROB_TICKET
- st_head_data  in  DATA_WIDTH  store data
- ld_pop / st_pop  out  1  pop served head
- cache_req  out  1  port request; cache_we  out  1  1=store
- cache_address  out  ADDR_BITS; cache_wdata  out  DATA_WIDTH; cache_microop  out  MICROOP
- cache_gnt  in  1  port accepts request this cycle
- cache_rvalid  in  1; cache_rdata  in  DATA_WIDTH  load return
- miss_req  out  1; miss_address  out  ADDR_BITS  block address, low BLOCK_ID_START bits zero
- miss_ack  in  1  miss accepted
- wb_valid  out  1; wb_data  out  DATA_WIDTH; wb_dest  out  R_WIDTH; wb_ticket  out  ROB_TICKET; wb_microop  out  MICROOP

## Operation
- FSM: IDLE, ISSUE, LD_WAIT, LD_WB.
- Eligibility: ld_elig = ld_valid & ld_head_isfetched; st_elig = st_valid & st_head_isfetched.
- RAW rule: both valid and heads share block ID (bits ADDR_BITS-1:BLOCK_ID_START) -> load ineligible until store popped.
- Selection in IDLE: load wins by default; store wins if only store eligible or starvation counter == STARVE_LIMIT.
- Starvation counter: +1 per load grant while st_elig; cleared on any store grant; saturates at STARVE_LIMIT.
- IDLE -> ISSUE: latch address/data/microop/dest/ticket/we of selected head; cache_* driven from latches only.
- ISSUE: cache_req held with stable payload until cache_gnt. Store: st_pop=1 in gnt cycle, -> IDLE. Load: -> LD_WAIT.
- LD_WAIT: wait for cache_rvalid; latch cache_rdata; -> LD_WB.
- LD_WB: wb_valid=1 and ld_pop=1 for exactly one cycle with latched fields; -> IDLE.
- Miss path (independent of FSM): per side flag miss_sent. Candidate = valid & !isfetched & !miss_sent; load candidate first. miss_req held with stable miss_address until miss_ack; on ack set that side's flag, and the other side's flag if its head shares the block. Flag cleared on that side's pop.
- Pops never coincide with each other; at most one cache transaction outstanding.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, miss_sent flags 0. Reset mid-transaction abandons it; cache_req/miss_req low after the reset edge.
- Eligible in IDLE at cycle N -> cache_req high N+1. Zero-wait gnt: store pops N+1, next issue N+3.
- Load: rvalid at M -> wb_valid/ld_pop at M+1, IDLE at M+2.
- cache_gnt and miss_ack ignored when corresponding req low.
- Head changing after latch does not affect in-flight payload.
- Both buffers empty: FSM stays IDLE, no outputs toggle.

## Configuration
- LDST_CTRL_STARVE_EN defined: starvation counter and STARVE_LIMIT override active.
- Undefined: counter removed; strict load priority (RAW rule still forces stores ahead of same-block loads).

## Test plan
- Single store, isfetched=1, gnt immediate -> cache_req at N+1 with cache_we=1, st_pop at N+1, no wb_valid.
- Single load addr 0x100, gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF -> wb_valid one cycle with data 0xDEADBEEF, dest/ticket matching, ld_pop same cycle.
- Both heads eligible, different blocks, loads continuously refilled, STARVE_LIMIT=4 -> 4 load grants then a store grant (macro on); loads only (macro off).
- Load 0x204 and store 0x208 same block, both fetched -> store issued first, load only after st_pop.
- Both heads unfetched same block 0x300/0x31C -> one miss_req with miss_address 0x300, held 3 cycles until ack, no second miss_req.
- Assert rst_n low during LD_WAIT -> all outputs 0 next cycle, later rvalid produces no wb_valid.
